muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for the RV32M operations that the ALU control decodes when IsMul=1.

---
 rtl/muldiv_pkg.sv | 77 +++++++
 rtl/muldiv_step.sv | 59 +++++
 rtl/muldiv_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide sequencer.
//  XLEN / CNT_W   : datapath and iteration-counter widths.
//  ALU_OPERATION_*: M-extension command codes. These values must stay identical to
//                   the ALU control decode (riscv_ctrl_para.v).
//  state_e        : sequencer FSM states.
//  step_mode_e    : iteration kind selected for muldiv_step.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [3:0] ALU_OPERATION_MUL   = 4'd0;
  localparam logic [3:0] ALU_OPERATION_MULH  = 4'd1;
  localparam logic [3:0] ALU_OPERATION_MULSU = 4'd2;
  localparam logic [3:0] ALU_OPERATION_MULU  = 4'd3;
  localparam logic [3:0] ALU_OPERATION_DIV   = 4'd4;
  localparam logic [3:0] ALU_OPERATION_DIVU  = 4'd5;
  localparam logic [3:0] ALU_OPERATION_REM   = 4'd6;
  localparam logic [3:0] ALU_OPERATION_REMU  = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  // True for any of the eight M-extension codes.
  function automatic logic cmd_valid(input logic [3:0] cmd);
    logic v;
    case (cmd)
      ALU_OPERATION_MUL, ALU_OPERATION_MULH, ALU_OPERATION_MULSU, ALU_OPERATION_MULU,
      ALU_OPERATION_DIV, ALU_OPERATION_DIVU, ALU_OPERATION_REM, ALU_OPERATION_REMU: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Operand A is treated as two's complement.
  function automatic logic cmd_a_signed(input logic [3:0] cmd);
    logic v;
    case (cmd)
      ALU_OPERATION_MUL, ALU_OPERATION_MULH, ALU_OPERATION_MULSU,
      ALU_OPERATION_DIV, ALU_OPERATION_REM: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Operand B is treated as two's complement (MULSU keeps rs2 unsigned).
  function automatic logic cmd_b_signed(input logic [3:0] cmd);
    logic v;
    case (cmd)
      ALU_OPERATION_MUL, ALU_OPERATION_MULH,
      ALU_OPERATION_DIV, ALU_OPERATION_REM: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Divide family (selects the restoring-divide iteration).
  function automatic logic cmd_is_div(input logic [3:0] cmd);
    logic v;
    case (cmd)
      ALU_OPERATION_DIV, ALU_OPERATION_DIVU, ALU_OPERATION_REM, ALU_OPERATION_REMU: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration on unsigned magnitudes.
//  mode_i    : STEP_MUL (shift-add) or STEP_DIV (restoring subtract).
//  acc_i     : 2*XLEN accumulator.
//              mul: {partial product high, remaining multiplier bits}, LSB first.
//              div: {partial remainder, remaining dividend / built quotient}, MSB first.
//  operand_i : multiplicand (mul) or divisor (div) magnitude.
//  acc_o     : accumulator after this step (div: bit 0 left clear for the quotient bit).
//  q_bit_o   : quotient bit produced by a divide step, 0 for multiply.
module muldiv_step
  import muldiv_pkg::*;
(
  input  step_mode_e          mode_i,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     operand_i,
  output logic [2*XLEN-1:0]   acc_o,
  output logic                q_bit_o
);

  logic [XLEN-1:0] addend_s;
  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   rem_sh_s;
  logic [XLEN:0]   diff_s;
  logic            fits_s;

  // Multiply: add the multiplicand when the current multiplier bit is set; the
  // carry out lands in the top bit after the right shift.
  assign addend_s = acc_i[0] ? operand_i : {XLEN{1'b0}};
  assign sum_s    = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, addend_s};

  // Divide: shift the next dividend bit into the remainder. The remainder is
  // always below 2*divisor, so bit XLEN of the difference is a clean borrow flag.
  assign rem_sh_s = acc_i[2*XLEN-1:XLEN-1];
  assign diff_s   = rem_sh_s - {1'b0, operand_i};
  assign fits_s   = ~diff_s[XLEN];

  // Select the iteration result for the current mode.
  always_comb begin
    acc_o   = {2*XLEN{1'b0}};
    q_bit_o = 1'b0;
    case (mode_i)
      STEP_MUL: begin
        acc_o = {sum_s, acc_i[XLEN-1:1]};
      end
      STEP_DIV: begin
        q_bit_o = fits_s;
        if (fits_s) begin
          acc_o = {diff_s[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end else begin
          acc_o = {rem_sh_s[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end
      end
      default: begin
        acc_o   = {2*XLEN{1'b0}};
        q_bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit beside the EX-stage ALU.
//  clk, rst            : rising-edge clock, asynchronous active-high reset.
//  start_i, is_mul_i   : request valid, qualified by IsMul from ALU control.
//  alu_cmd_i           : ALU_OPERATION_{MUL..REMU}.
//  rs1_i, rs2_i        : operand A (multiplicand/dividend), operand B (multiplier/divisor).
//  flush_i             : synchronous abort; wins over start_i.
//  ready_o             : 1 only in IDLE.
//  stall_o             : pipeline hold request (combinational).
//  done_o              : 1-cycle result-valid pulse (DONE state).
//  result_o            : registered result, held until replaced by a later completion.
// Flow: IDLE -> PREP -> ITER (XLEN steps) -> FIX -> DONE -> IDLE; special cases and
// unknown commands go PREP -> DONE directly.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            is_mul_i,
  input  logic [3:0]      alu_cmd_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_e            state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_rem_q, neg_rem_d;

  logic              sign_a_s, sign_b_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic              is_div_s, is_rem_s, div_zero_s, div_ovf_s;
  step_mode_e        mode_s;
  logic [2*XLEN-1:0] step_acc_s;
  logic              step_q_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

  // Operand decode used in PREP: signs only count for signed operand positions.
  assign sign_a_s   = cmd_a_signed(cmd_q) & a_q[XLEN-1];
  assign sign_b_s   = cmd_b_signed(cmd_q) & b_q[XLEN-1];
  assign mag_a_s    = sign_a_s ? ({XLEN{1'b0}} - a_q) : a_q;
  assign mag_b_s    = sign_b_s ? ({XLEN{1'b0}} - b_q) : b_q;
  assign is_div_s   = cmd_is_div(cmd_q);
  assign is_rem_s   = (cmd_q == ALU_OPERATION_REM) | (cmd_q == ALU_OPERATION_REMU);
  assign div_zero_s = (b_q == {XLEN{1'b0}});
  // Only DIV/REM reach here with both operands signed.
  assign div_ovf_s  = cmd_b_signed(cmd_q) & (a_q == {1'b1, {(XLEN-1){1'b0}}}) &
                      (b_q == {XLEN{1'b1}});
  assign mode_s     = is_div_s ? STEP_DIV : STEP_MUL;

  muldiv_step u_step (
    .mode_i    (mode_s),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc_s),
    .q_bit_o   (step_q_s)
  );

  // Sign fix-up on the final unsigned accumulator (wraps mod 2^(2*XLEN)).
  assign prod_s = neg_lo_q  ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
  assign quot_s = neg_lo_q  ? ({XLEN{1'b0}} - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
  assign rem_s  = neg_rem_q ? ({XLEN{1'b0}} - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

  // Next-state and datapath-load logic.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_lo_d  = neg_lo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    if (flush_i && (state_q != ST_IDLE)) begin
      // Abort: drop the operation, leave result_q untouched.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && is_mul_i && !flush_i) begin
            cmd_d   = alu_cmd_i;
            a_d     = rs1_i;
            b_d     = rs2_i;
            state_d = ST_PREP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PREP: begin
          neg_lo_d  = sign_a_s ^ sign_b_s;
          neg_rem_d = sign_a_s;
          cnt_d     = CNT_W'(XLEN);
          if (!cmd_valid(cmd_q)) begin
            result_d = {XLEN{1'b0}};
            state_d  = ST_DONE;
          end else if (is_div_s && div_zero_s) begin
            result_d = is_rem_s ? a_q : {XLEN{1'b1}};
            state_d  = ST_DONE;
          end else if (is_div_s && div_ovf_s) begin
            result_d = is_rem_s ? {XLEN{1'b0}} : a_q;
            state_d  = ST_DONE;
          end else if (is_div_s) begin
            acc_d   = {{XLEN{1'b0}}, mag_a_s};
            opnd_d  = mag_b_s;
            state_d = ST_ITER;
          end else begin
            acc_d   = {{XLEN{1'b0}}, mag_b_s};
            opnd_d  = mag_a_s;
            state_d = ST_ITER;
          end
        end
        ST_ITER: begin
          acc_d = {step_acc_s[2*XLEN-1:1], step_acc_s[0] | step_q_s};
          cnt_d = cnt_q - CNT_W'(1);
          // The step taken while cnt_q==1 is the last of XLEN.
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_ITER;
          end
        end
        ST_FIX: begin
          case (cmd_q)
            ALU_OPERATION_MUL:                                          result_d = prod_s[XLEN-1:0];
            ALU_OPERATION_MULH, ALU_OPERATION_MULSU, ALU_OPERATION_MULU: result_d = prod_s[2*XLEN-1:XLEN];
            ALU_OPERATION_DIV, ALU_OPERATION_DIVU:                      result_d = quot_s;
            ALU_OPERATION_REM, ALU_OPERATION_REMU:                      result_d = rem_s;
            default:                                                    result_d = {XLEN{1'b0}};
          endcase
          state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= 4'd0;
      a_q       <= {XLEN{1'b0}};
      b_q       <= {XLEN{1'b0}};
      opnd_q    <= {XLEN{1'b0}};
      acc_q     <= {(2*XLEN){1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      neg_lo_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_lo_q  <= neg_lo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;
  // Hold the pipeline from the request cycle itself so the instruction stays in EX.
  assign stall_o  = ((state_q == ST_IDLE) & start_i & is_mul_i & ~flush_i) |
                    (state_q == ST_PREP) | (state_q == ST_ITER) | (state_q == ST_FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: expected results are queued when a
// request is driven and compared when done_o is seen.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, is_mul_i, flush_i;
  logic [3:0]  alu_cmd_i;
  logic [31:0] rs1_i, rs2_i;
  logic        ready_o, stall_o, done_o;
  logic [31:0] result_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_mul_i(is_mul_i), .alu_cmd_i(alu_cmd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i), .ready_o(ready_o), .stall_o(stall_o),
    .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  // Reference model of the RV32M result.
  function automatic logic [31:0] model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb, r;
    logic ovf;
    sa = a; sb = b; r = 32'sd0;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (cmd)
      ALU_OPERATION_MUL:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0];  end
      ALU_OPERATION_MULH:  begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      ALU_OPERATION_MULSU: begin p = {{32{a[31]}}, a} * {32'h0, b};       return p[63:32]; end
      ALU_OPERATION_MULU:  begin p = {32'h0, a} * {32'h0, b};             return p[63:32]; end
      ALU_OPERATION_DIV:   begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        r = sa / sb; return r;
      end
      ALU_OPERATION_DIVU:  return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      ALU_OPERATION_REM:   begin
        if (b == 32'h0) return a;
        if (ovf) return 32'h0;
        r = sa % sb; return r;
      end
      ALU_OPERATION_REMU:  return (b == 32'h0) ? a : a % b;
      default:             return 32'h0;
    endcase
  endfunction

  // Drive one request once the DUT is idle; returns just after the accept edge.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit track);
    @(negedge clk);
    for (int i = 0; i < 100 && ready_o !== 1'b1; i++) @(negedge clk);
    start_i = 1'b1; is_mul_i = 1'b1; alu_cmd_i = cmd; rs1_i = a; rs2_i = b;
    if (track) exp_q.push_back(exp);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Sample #1 after each edge until done_o or the bound; counts stall samples before done.
  task automatic wait_done(input int bound, output int cycles, output int stalls, output bit seen);
    cycles = 0; stalls = 0; seen = 1'b0;
    while (!seen && cycles < bound) begin
      @(posedge clk); #1;
      cycles++;
      if (done_o === 1'b1) seen = 1'b1;
      else if (stall_o === 1'b1) stalls++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL reset_done got %b want 0", done_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'h0) $display("FAIL reset_result got %h want 0", result_o); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [3:0]  c[4] = '{ALU_OPERATION_MUL, ALU_OPERATION_MULH, ALU_OPERATION_MULSU, ALU_OPERATION_MULU};
    logic [31:0] a[4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e[4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] got;
    int cyc, stl; bit seen;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int k = 0; k < 100 && ready_o !== 1'b1; k++) @(negedge clk);
      start_i = 1'b1; is_mul_i = 1'b1; alu_cmd_i = c[i]; rs1_i = a[i]; rs2_i = b[i];
      exp_q.push_back(e[i]);
      #1;
      total_cnt++; if (stall_o !== 1'b1) $display("FAIL mul_req_stall[%0d] got %b want 1", i, stall_o); else pass_cnt++;
      @(posedge clk); #1; start_i = 1'b0;
      wait_done(60, cyc, stl, seen);
      got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      total_cnt++; if (!seen || result_o !== got) $display("FAIL mul_result[%0d] got %h (done=%b) want %h", i, result_o, seen, got); else pass_cnt++;
      // Accept edge to done: PREP + XLEN ITER + FIX + DONE edge.
      total_cnt++; if (cyc != 34) $display("FAIL mul_latency[%0d] got %0d want 34", i, cyc); else pass_cnt++;
      // Stall samples after PREP: XLEN ITER cycles + FIX.
      total_cnt++; if (stl != 33) $display("FAIL mul_stall_cycles[%0d] got %0d want 33", i, stl); else pass_cnt++;
    end
  endtask

  task automatic test_div();
    logic [3:0]  c[4] = '{ALU_OPERATION_DIV, ALU_OPERATION_REM, ALU_OPERATION_DIVU, ALU_OPERATION_REMU};
    logic [31:0] a[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] e[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] got;
    int cyc, stl; bit seen;
    for (int i = 0; i < 4; i++) begin
      issue(c[i], a[i], b[i], e[i], 1'b1);
      wait_done(60, cyc, stl, seen);
      got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      total_cnt++; if (!seen || result_o !== got) $display("FAIL div_result[%0d] got %h (done=%b) want %h", i, result_o, seen, got); else pass_cnt++;
      total_cnt++; if (cyc != 34) $display("FAIL div_latency[%0d] got %0d want 34", i, cyc); else pass_cnt++;
    end
  endtask

  task automatic test_bad_cmd();
    logic [31:0] got;
    int cyc, stl; bit seen;
    issue(4'hF, 32'd5, 32'd6, 32'h0, 1'b1);
    wait_done(60, cyc, stl, seen);
    got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    total_cnt++; if (!seen || result_o !== got) $display("FAIL bad_cmd_result got %h (done=%b) want %h", result_o, seen, got); else pass_cnt++;
    total_cnt++; if (cyc != 1) $display("FAIL bad_cmd_latency got %0d want 1", cyc); else pass_cnt++;
  endtask

  task automatic test_special();
    logic [3:0]  c[5] = '{ALU_OPERATION_DIV, ALU_OPERATION_REM, ALU_OPERATION_DIVU, ALU_OPERATION_DIV, ALU_OPERATION_REM};
    logic [31:0] a[5] = '{32'd1234, 32'd1234, 32'd55, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b[5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e[5] = '{32'hFFFF_FFFF, 32'd1234, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    logic [31:0] got;
    int cyc, stl; bit seen;
    for (int i = 0; i < 5; i++) begin
      issue(c[i], a[i], b[i], e[i], 1'b1);
      wait_done(60, cyc, stl, seen);
      got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      total_cnt++; if (!seen || result_o !== got) $display("FAIL special_result[%0d] got %h (done=%b) want %h", i, result_o, seen, got); else pass_cnt++;
      // PREP then straight to DONE.
      total_cnt++; if (cyc != 1) $display("FAIL special_latency[%0d] got %0d want 1", i, cyc); else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, got;
    int cyc, stl; bit seen;
    prev = result_o;
    issue(ALU_OPERATION_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL flush_ready got %b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL flush_stall got %b want 0", stall_o); else pass_cnt++;
    total_cnt++; if (result_o !== prev) $display("FAIL flush_result_held got %h want %h", result_o, prev); else pass_cnt++;
    wait_done(45, cyc, stl, seen);
    total_cnt++; if (seen) $display("FAIL flush_no_done got done after %0d cycles want none", cyc); else pass_cnt++;
    issue(ALU_OPERATION_DIVU, 32'd9, 32'd3, 32'd3, 1'b1);
    wait_done(60, cyc, stl, seen);
    got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    total_cnt++; if (!seen || result_o !== got) $display("FAIL flush_after_divu got %h (done=%b) want %h", result_o, seen, got); else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    int cyc, stl; bit seen;
    issue(ALU_OPERATION_MULU, 32'd5, 32'd6, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL rst_mid_stall got %b want 0", stall_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'h0) $display("FAIL rst_mid_result got %h want 0", result_o); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    wait_done(45, cyc, stl, seen);
    total_cnt++; if (seen) $display("FAIL rst_mid_no_done got done after %0d cycles want none", cyc); else pass_cnt++;
  endtask

  task automatic test_busy_start();
    logic [31:0] got;
    int cyc, stl; bit seen;
    issue(ALU_OPERATION_DIVU, 32'd1000, 32'd10, 32'd100, 1'b1);
    repeat (3) begin
      @(negedge clk); start_i = 1'b1; is_mul_i = 1'b1; alu_cmd_i = ALU_OPERATION_MUL; rs1_i = 32'd2; rs2_i = 32'd3;
    end
    @(negedge clk); start_i = 1'b0;
    wait_done(60, cyc, stl, seen);
    got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    total_cnt++; if (!seen || result_o !== got) $display("FAIL busy_result got %h (done=%b) want %h", result_o, seen, got); else pass_cnt++;
    wait_done(45, cyc, stl, seen);
    total_cnt++; if (seen) $display("FAIL busy_no_queue got done after %0d cycles want none", cyc); else pass_cnt++;
  endtask

  task automatic test_not_mul();
    int cyc, stl; bit seen;
    @(negedge clk);
    start_i = 1'b1; is_mul_i = 1'b0; alu_cmd_i = ALU_OPERATION_MUL; rs1_i = 32'd4; rs2_i = 32'd4;
    #1;
    total_cnt++; if (stall_o !== 1'b0) $display("FAIL not_mul_stall got %b want 0", stall_o); else pass_cnt++;
    repeat (3) @(posedge clk); #1;
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL not_mul_ready got %b want 1", ready_o); else pass_cnt++;
    wait_done(40, cyc, stl, seen);
    total_cnt++; if (seen) $display("FAIL not_mul_no_done got done after %0d cycles want none", cyc); else pass_cnt++;
    @(negedge clk); start_i = 1'b0; is_mul_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cmd;
    logic [31:0] a, b, got;
    int cyc, stl; bit seen;
    for (int i = 0; i < 8; i++) begin
      cmd = 4'($urandom_range(0, 7));
      a   = $urandom;
      b   = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      issue(cmd, a, b, model(cmd, a, b), 1'b1);
      wait_done(60, cyc, stl, seen);
      got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      total_cnt++; if (!seen || result_o !== got) $display("FAIL b2b_result[%0d] cmd=%0d a=%h b=%h got %h (done=%b) want %h", i, cmd, a, b, result_o, seen, got); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (done_o !== 1'b0 || ready_o !== 1'b1) $display("FAIL b2b_pulse[%0d] got done=%b ready=%b want done=0 ready=1", i, done_o, ready_o); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; is_mul_i = 1'b0; flush_i = 1'b0;
    alu_cmd_i = 4'd0; rs1_i = 32'd0; rs2_i = 32'd0;
    test_reset();
    test_mul();
    test_div();
    test_bad_cmd();
    test_special();
    test_flush();
    test_rst_mid();
    test_busy_start();
    test_not_mul();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
